// File: rtl/adc_spi_emulator_pkg.sv
// Shared definitions for the ADC SPI emulator and the SPI reader that consumes its frames.
package adc_spi_emulator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int DEF_FRAME_BITS = 16;
    localparam int DEF_LEAD_ZEROS = 4;

endpackage

// File: rtl/adc_spi_emulator_sync_edge_detect.sv
// Two-flop synchronizer for an asynchronous level, plus a delay register that
// produces single-cycle rise/fall pulses in the clk domain.
module sync_edge_detect #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_b,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
            prev_q <= RESET_VAL;
        end else begin
            meta_q <= din;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign level = sync_q;
    assign rise  = sync_q & ~prev_q;
    assign fall  = ~sync_q & prev_q;

endmodule

// File: rtl/adc_spi_emulator.sv
// SPI slave that emulates an ADC: queues samples in a small FIFO and serialises
// one per CS-framed transfer as {LEAD_ZEROS zeros, sample, tail zeros}, MSB first.
module adc_spi_emulator
    import adc_spi_emulator_pkg::*;
#(
    parameter int SAMPLE_WIDTH = 10,
    parameter int LEAD_ZEROS   = DEF_LEAD_ZEROS,
    parameter int FRAME_BITS   = DEF_FRAME_BITS,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                            clk,
    input  logic                            reset_b,
    input  logic                            SPI_clk,
    input  logic                            CS,
    output logic                            SPI_Data_out,
    input  logic [SAMPLE_WIDTH-1:0]         Sample_in,
    input  logic                            Sample_Valid,
    output logic                            Sample_Ready,
    output logic                            Frame_Done,
    output logic                            Underrun,
    output logic [$clog2(FIFO_DEPTH):0]     Fifo_Count,
    output state_t                          fsm_state
);

    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int CNT_W      = PTR_W + 1;
    localparam int BIT_W      = $clog2(FRAME_BITS + 1);
    localparam int TAIL_ZEROS = FRAME_BITS - LEAD_ZEROS - SAMPLE_WIDTH;

    logic spi_level, spi_rise, spi_fall;
    logic cs_level, cs_rise, cs_fall;
    logic unused_spi;

    sync_edge_detect #(.RESET_VAL(1'b0)) u_spi_sync (
        .clk(clk), .reset_b(reset_b), .din(SPI_clk),
        .level(spi_level), .rise(spi_rise), .fall(spi_fall)
    );

    sync_edge_detect #(.RESET_VAL(1'b1)) u_cs_sync (
        .clk(clk), .reset_b(reset_b), .din(CS),
        .level(cs_level), .rise(cs_rise), .fall(cs_fall)
    );

    assign unused_spi = spi_level | spi_rise;

    logic [SAMPLE_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr, rd_ptr;
    logic [CNT_W-1:0]        count;
    logic                    push, pop, fifo_empty;

    // Handshake: a sample transfers on any clk edge where Sample_Valid and
    // Sample_Ready are both high; Sample_Ready depends only on registered
    // occupancy, so a pop in the same cycle never opens room for a push.
    assign Sample_Ready = (count < CNT_W'(FIFO_DEPTH));
    assign push         = Sample_Valid && Sample_Ready;
    assign fifo_empty   = (count == '0);
    assign pop          = (fsm_state == ST_LOAD) && !fifo_empty;
    assign Fifo_Count   = count;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= Sample_in;
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    logic [SAMPLE_WIDTH-1:0] last_sample, sel_sample;
    logic [FRAME_BITS-1:0]   load_word;
    logic [FRAME_BITS-2:0]   shift_reg;
    logic [BIT_W-1:0]        bit_cnt;

    // On underrun the previous sample is resent.
    assign sel_sample = fifo_empty ? last_sample : mem[rd_ptr];
    assign load_word  = FRAME_BITS'(sel_sample) << TAIL_ZEROS;

    // shift_reg holds only the bits still to be sent; the current bit lives in SPI_Data_out.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            fsm_state    <= ST_IDLE;
            SPI_Data_out <= 1'b0;
            Frame_Done   <= 1'b0;
            Underrun     <= 1'b0;
            last_sample  <= '0;
            shift_reg    <= '0;
            bit_cnt      <= '0;
            rd_ptr       <= '0;
        end else begin
            Frame_Done <= 1'b0;
            case (fsm_state)
                ST_IDLE: begin
                    SPI_Data_out <= 1'b0;
                    if (cs_fall) fsm_state <= ST_LOAD;
                end
                ST_LOAD: begin
                    if (fifo_empty) begin
                        Underrun <= 1'b1;
                    end else begin
                        last_sample <= mem[rd_ptr];
                        rd_ptr      <= rd_ptr + 1'b1;
                    end
                    shift_reg <= load_word[FRAME_BITS-2:0];
                    bit_cnt   <= '0;
                    if (cs_rise) begin
                        fsm_state    <= ST_IDLE;
                        SPI_Data_out <= 1'b0;
                    end else begin
                        fsm_state    <= ST_SHIFT;
                        SPI_Data_out <= load_word[FRAME_BITS-1];
                    end
                end
                ST_SHIFT: begin
                    if (cs_rise) begin
                        fsm_state    <= ST_IDLE;
                        SPI_Data_out <= 1'b0;
                    end else if (spi_fall) begin
                        shift_reg    <= {shift_reg[FRAME_BITS-3:0], 1'b0};
                        SPI_Data_out <= shift_reg[FRAME_BITS-2];
                        bit_cnt      <= bit_cnt + 1'b1;
                        if (bit_cnt == BIT_W'(FRAME_BITS - 1)) begin
                            fsm_state    <= ST_DONE;
                            Frame_Done   <= 1'b1;
                            SPI_Data_out <= 1'b0;
                        end
                    end
                end
                ST_DONE: begin
                    SPI_Data_out <= 1'b0;
                    if (cs_level) fsm_state <= ST_IDLE;
                end
                default: begin
                    fsm_state    <= ST_IDLE;
                    SPI_Data_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_spi_emulator.sv
// Directed bench: a behavioural SPI master captures frames; a monitor compares
// each captured frame against a queue of expected words when Frame_Done pulses.
module tb_adc_spi_emulator;
    import adc_spi_emulator_pkg::*;

    localparam int SW = 10;

    logic          clk = 1'b0;
    logic          reset_b = 1'b0;
    logic          SPI_clk = 1'b0;
    logic          CS = 1'b1;
    logic          SPI_Data_out;
    logic [SW-1:0] Sample_in = '0;
    logic          Sample_Valid = 1'b0;
    logic          Sample_Ready;
    logic          Frame_Done;
    logic          Underrun;
    logic [2:0]    Fifo_Count;
    state_t        fsm_state;

    logic [15:0] exp_q[$];
    logic [15:0] cap = '0;
    int checks = 0;
    int errors = 0;
    int fd_cnt = 0;
    int exp_fd = 0;

    adc_spi_emulator dut (
        .clk(clk), .reset_b(reset_b), .SPI_clk(SPI_clk), .CS(CS),
        .SPI_Data_out(SPI_Data_out), .Sample_in(Sample_in),
        .Sample_Valid(Sample_Valid), .Sample_Ready(Sample_Ready),
        .Frame_Done(Frame_Done), .Underrun(Underrun),
        .Fifo_Count(Fifo_Count), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Master samples on SPI_clk rising edges while CS is low.
    always @(posedge SPI_clk) if (!CS) cap = {cap[14:0], SPI_Data_out};
    always @(negedge CS) cap = '0;

    always @(negedge clk) begin
        if (reset_b && Frame_Done) begin
            fd_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_frame actual=%0h expected=none", cap);
            end else begin
                check("frame_data", cap, exp_q.pop_front());
            end
        end
    end

    task automatic push(input logic [SW-1:0] v);
        @(negedge clk);
        Sample_in = v;
        Sample_Valid = 1'b1;
        @(negedge clk);
        Sample_Valid = 1'b0;
    endtask

    task automatic spi_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            SPI_clk = 1'b1;
            repeat (8) @(negedge clk);
            SPI_clk = 1'b0;
            repeat (8) @(negedge clk);
        end
    endtask

    task automatic cs_low();
        @(negedge clk);
        CS = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic cs_high();
        CS = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic full_frame();
        cs_low();
        spi_cycles(16);
        cs_high();
        exp_fd++;
    endtask

    task automatic expect_sample(input logic [SW-1:0] s);
        exp_q.push_back({4'b0000, s, 2'b00});
    endtask

    initial begin
        bit found;

        repeat (3) @(negedge clk);
        check("rst_count", Fifo_Count, 3'd0);
        check("rst_ready", Sample_Ready, 1'b1);
        check("rst_underrun", Underrun, 1'b0);
        check("rst_data", SPI_Data_out, 1'b0);
        check("rst_frame_done", Frame_Done, 1'b0);
        check("rst_state", fsm_state, ST_IDLE);
        reset_b = 1'b1;
        repeat (3) @(negedge clk);

        // Single frame with a known pattern.
        push(10'h2A5);
        check("count_after_push", Fifo_Count, 3'd1);
        exp_q.push_back(16'h0A94);
        full_frame();
        check("fd_single", fd_cnt, exp_fd);
        check("count_drained", Fifo_Count, 3'd0);
        check("underrun_clear", Underrun, 1'b0);

        // Fill to full, refuse a fifth push, drain in order.
        for (int i = 1; i <= 4; i++) push(SW'(i));
        check("count_full", Fifo_Count, 3'd4);
        check("ready_full", Sample_Ready, 1'b0);
        push(10'h05A);
        check("count_refused", Fifo_Count, 3'd4);
        for (int i = 1; i <= 4; i++) begin
            expect_sample(SW'(i));
            full_frame();
        end
        check("count_after_four", Fifo_Count, 3'd0);
        check("fd_four", fd_cnt, exp_fd);
        check("underrun_after_four", Underrun, 1'b0);

        // Underrun repeats the last sample and the flag sticks.
        push(10'h3FF);
        expect_sample(10'h3FF);
        expect_sample(10'h3FF);
        full_frame();
        full_frame();
        check("underrun_set", Underrun, 1'b1);
        repeat (20) @(negedge clk);
        check("underrun_sticky", Underrun, 1'b1);
        check("fd_underrun", fd_cnt, exp_fd);

        // Abort after 7 bits: no Frame_Done, popped sample lost.
        push(10'h0AA);
        push(10'h0BB);
        cs_low();
        spi_cycles(7);
        cs_high();
        check("abort_data", SPI_Data_out, 1'b0);
        check("abort_no_fd", fd_cnt, exp_fd);
        check("abort_count", Fifo_Count, 3'd1);
        check("abort_state", fsm_state, ST_IDLE);
        expect_sample(10'h0BB);
        full_frame();
        check("fd_after_abort", fd_cnt, exp_fd);

        // Reset in the middle of a frame with three samples queued.
        push(10'h111);
        push(10'h222);
        push(10'h333);
        check("count_three", Fifo_Count, 3'd3);
        cs_low();
        spi_cycles(9);
        @(negedge clk);
        reset_b = 1'b0;
        #1;
        check("midrst_count", Fifo_Count, 3'd0);
        check("midrst_underrun", Underrun, 1'b0);
        check("midrst_data", SPI_Data_out, 1'b0);
        check("midrst_state", fsm_state, ST_IDLE);
        CS = 1'b1;
        repeat (5) @(negedge clk);
        reset_b = 1'b1;
        repeat (5) @(negedge clk);
        expect_sample(10'h000);
        full_frame();
        check("postrst_underrun", Underrun, 1'b1);
        check("postrst_count", Fifo_Count, 3'd0);

        // Push attempted in the LOAD cycle while full: refused.
        for (int i = 1; i <= 4; i++) push(SW'(10'h100 + i));
        check("count_full2", Fifo_Count, 3'd4);
        expect_sample(10'h101);
        @(negedge clk);
        CS = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (fsm_state == ST_LOAD) begin
                found = 1'b1;
                break;
            end
        end
        check("load_seen", found, 1'b1);
        Sample_in = 10'h1EE;
        Sample_Valid = 1'b1;
        check("ready_in_load", Sample_Ready, 1'b0);
        @(negedge clk);
        Sample_Valid = 1'b0;
        check("count_pop_refused", Fifo_Count, 3'd3);
        repeat (5) @(negedge clk);
        spi_cycles(16);
        cs_high();
        exp_fd++;
        for (int i = 2; i <= 4; i++) begin
            expect_sample(SW'(10'h100 + i));
            full_frame();
        end
        check("final_count", Fifo_Count, 3'd0);
        check("final_fd", fd_cnt, exp_fd);
        check("final_queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adc_spi_emulator.md
ADC_SPI_EMULATOR -- requirements
Module: adc_spi_emulator

Interface
REQ-001 The module SHALL have parameter SAMPLE_WIDTH, default 10, giving the ADC sample width in bits.
REQ-002 The module SHALL have parameter LEAD_ZEROS, default 4, giving the count of zero bits sent before the sample MSB.
REQ-003 The module SHALL have parameter FRAME_BITS, default 16, giving the total SPI_clk falling edges per frame.
REQ-004 The module SHALL have parameter FIFO_DEPTH, default 4 (power of 2), giving the sample queue depth.
REQ-005 The module SHALL have port clk, input, 1 bit: the single system clock; all state is in this domain.
REQ-006 The module SHALL have port reset_b, input, 1 bit: asynchronous, active-low reset.
REQ-007 The module SHALL have port SPI_clk, input, 1 bit: serial clock from the SPI master, asynchronous to clk.
REQ-008 The module SHALL have port CS, input, 1 bit: active-low chip select from the master, asynchronous to clk.
REQ-009 The module SHALL have port SPI_Data_out, output, 1 bit: serial data to the master's SPI_Data_in.
REQ-010 The module SHALL have port Sample_in, input, SAMPLE_WIDTH bits: the sample to queue.
REQ-011 The module SHALL have port Sample_Valid, input, 1 bit: Sample_in is valid this cycle.
REQ-012 The module SHALL have port Sample_Ready, output, 1 bit: the FIFO can accept a sample.
REQ-013 The module SHALL have port Frame_Done, output, 1 bit: a one-clk pulse marking a completed full frame.
REQ-014 The module SHALL have port Underrun, output, 1 bit: sticky flag, set when a frame started with the FIFO empty.
REQ-015 The module SHALL have port Fifo_Count, output, clog2(FIFO_DEPTH)+1 bits: the current FIFO occupancy.

Function
REQ-016 SPI_clk and CS SHALL each pass through a 2-flop synchronizer followed by one edge-detect register; clk >= 8x SPI_clk is a usage requirement.
REQ-017 A push SHALL occur when Sample_Valid && Sample_Ready; Sample_Ready = (Fifo_Count < FIFO_DEPTH), computed from registered state.
REQ-018 When the FIFO is full and a pop occurs in the same cycle, the push SHALL be refused; Sample_Ready stays low that cycle.
REQ-019 FSM states SHALL be IDLE, LOAD, SHIFT, DONE.
REQ-020 IDLE SHALL wait for a synchronized CS falling edge, then go to LOAD.
REQ-021 LOAD SHALL last one cycle: if the FIFO is non-empty, pop the head into Last_Sample; otherwise keep Last_Sample and set Underrun. The shift register SHALL be built as {LEAD_ZEROS zeros, Last_Sample, FRAME_BITS-LEAD_ZEROS-SAMPLE_WIDTH zeros}, SPI_Data_out SHALL be driven with its MSB, and the bit counter SHALL be cleared. Next state is SHIFT.
REQ-022 In SHIFT, each synchronized SPI_clk falling edge SHALL shift left by one (zero fill) and increment the bit counter; SPI_Data_out SHALL be valid before the next SPI_clk rising edge.
REQ-023 When the bit counter reaches FRAME_BITS, SHIFT SHALL go to DONE; DONE SHALL pulse Frame_Done for one clk, force SPI_Data_out=0, and wait for CS high before returning to IDLE.
REQ-024 A CS rising edge in LOAD or SHIFT SHALL abort the frame: return to IDLE, no Frame_Done, SPI_Data_out=0, and the already-popped sample is not re-queued.
REQ-025 SPI_Data_out SHALL be 0 whenever the state is IDLE or DONE.
REQ-026 SPI_clk edges outside SHIFT SHALL be ignored.
REQ-027 A CS falling edge coincident with a push SHALL see the pushed sample only if the FIFO was otherwise empty in the following LOAD cycle, i.e. the pop SHALL use post-push occupancy.
REQ-028 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH; Fifo_Count SHALL never exceed FIFO_DEPTH or go below 0.
REQ-029 Underrun SHALL clear only on reset.

Reset
REQ-030 On reset_b low, the module SHALL asynchronously return to IDLE and set SPI_Data_out=0, Frame_Done=0, Underrun=0, Fifo_Count=0, Sample_Ready=1, Last_Sample=0, and pointers, counter and synchronizers to 0 (CS synchronizer to 1).
REQ-031 Reset asserted mid-frame SHALL discard the frame and all FIFO contents.

Structure
REQ-032 A shared package SHALL hold the FSM state encoding (2 bits) and the FRAME_BITS/LEAD_ZEROS defaults used by the existing SPI reader.
REQ-033 One sub-module, sync_edge_detect (2-flop sync plus rise/fall pulse outputs, reset value parameterized), SHALL be instantiated twice, once for SPI_clk and once for CS.

Verification
REQ-034 The bench SHALL push 10'h2A5, then drive CS low and 16 SPI_clk cycles, and require the master to capture 16'h0A94 ({4'b0, 10'h2A5, 2'b00}), with one Frame_Done pulse.
REQ-035 The bench SHALL push 1, 2, 3, 4 (FIFO full), check Sample_Ready=0 and a fifth push refused, then run 4 frames and require 1, 2, 3, 4 in order with Fifo_Count reaching 0.
REQ-036 The bench SHALL push 10'h3FF, run 2 frames, and require the second frame to repeat 10'h3FF with Underrun=1 and staying 1.
REQ-037 The bench SHALL raise CS after 7 SPI_clk edges and require no Frame_Done, SPI_Data_out=0, and the next frame to carry the next FIFO entry.
REQ-038 The bench SHALL assert reset_b low at bit 9 of a frame with 3 queued samples and require Fifo_Count=0, Underrun=0, SPI_Data_out=0, and a subsequent frame sending 0 with Underrun=1.
REQ-039 The bench SHALL push while full and pop in the same cycle, and require the push refused and Fifo_Count=3 afterward.
